// File: rtl/sequence_detector_param_pkg.sv
// Shared constants and elaboration helpers for the parametrised sequence detector.
package sequence_detector_pkg;

    // Reset-time pattern of the original fixed detector.
    localparam logic [3:0] DEFAULT_PATTERN_1011 = 4'b1011;

    // Width of a counter that must hold every value from 0 up to pattern_w inclusive.
    function automatic int unsigned fill_width(input int unsigned pattern_w);
        return $clog2(pattern_w + 1);
    endfunction

endpackage

// File: rtl/sequence_detector_param_if.sv
// Stream, control and result signals of the sequence detector, grouped as one bundle.
interface sequence_detector_param_if #(
    parameter int unsigned PATTERN_W = 4,
    parameter int unsigned COUNT_W   = 8
) ();

    logic                 sequence_in;
    logic                 in_valid;
    logic                 overlap_en;
    logic                 pattern_load;
    logic [PATTERN_W-1:0] pattern_in;
    logic                 count_clr;
    logic                 detector_out;
    logic [COUNT_W-1:0]   match_count;
    logic                 count_sat;

    // Bit-stream source / controller side.
    modport master (
        output sequence_in, in_valid, overlap_en, pattern_load, pattern_in, count_clr,
        input  detector_out, match_count, count_sat
    );

    // Detector side.
    modport slave (
        input  sequence_in, in_valid, overlap_en, pattern_load, pattern_in, count_clr,
        output detector_out, match_count, count_sat
    );

endinterface

// File: rtl/sequence_detector_param_counter.sv
// Saturating match counter: clear has priority but a same-cycle increment still lands.
module seq_match_counter #(
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               inc,
    output logic [COUNT_W-1:0] count,
    output logic               sat
);

    // Count register: clear-then-count, hold once all ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? COUNT_W'(1) : '0;
        end else if (inc && !sat) begin
            count <= count + COUNT_W'(1);
        end
    end

    // Saturation flag decoded from the registered count.
    always_comb begin
        sat = &count;
    end

endmodule

// File: rtl/sequence_detector_param.sv
// Parametrised serial pattern detector with runtime pattern reload, per-bit overlap
// selection, valid-qualified input and a saturating match counter.
module sequence_detector_param
    import sequence_detector_pkg::*;
#(
    parameter int unsigned          PATTERN_W       = 4,
    parameter logic [PATTERN_W-1:0] DEFAULT_PATTERN = DEFAULT_PATTERN_1011,
    parameter int unsigned          COUNT_W         = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    sequence_detector_param_if.slave bus
);

    localparam int unsigned FILL_W = fill_width(PATTERN_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

    logic [PATTERN_W-1:0] pattern;
    logic [PATTERN_W-1:0] history;
    logic [FILL_W-1:0]    fill;
    logic                 detector_q;

    logic [PATTERN_W-1:0] cand;
    logic [FILL_W-1:0]    fill_inc;
    logic                 match;
    logic                 accept;
    logic                 hit;

    // Candidate window and match decision for the bit offered this cycle.
    always_comb begin
        cand     = {history[PATTERN_W-2:0], bus.sequence_in};
        fill_inc = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
        match    = (fill_inc == FILL_FULL) && (cand == pattern);
        accept   = bus.in_valid && !bus.pattern_load;
        hit      = accept && match;
    end

    // Pattern, history, fill and pulse registers; a load wins over an accepted bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pattern    <= DEFAULT_PATTERN;
            history    <= '0;
            fill       <= '0;
            detector_q <= 1'b0;
        end else if (bus.pattern_load) begin
            pattern    <= bus.pattern_in;
            history    <= '0;
            fill       <= '0;
            detector_q <= 1'b0;
        end else if (bus.in_valid) begin
            history    <= cand;
            detector_q <= match;
            if (match) begin
                // Non-overlap restarts the fill so the matched bits cannot be reused.
                fill <= bus.overlap_en ? FILL_FULL : '0;
            end else begin
                fill <= fill_inc;
            end
        end else begin
            detector_q <= 1'b0;
        end
    end

    seq_match_counter #(
        .COUNT_W (COUNT_W)
    ) u_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (bus.count_clr),
        .inc     (hit),
        .count   (bus.match_count),
        .sat     (bus.count_sat)
    );

    // Drive the registered pulse onto the bundle.
    always_comb begin
        bus.detector_out = detector_q;
    end

endmodule

// File: tb/tb_sequence_detector_param.sv
// Scoreboard bench: stimulus pushes expected pulses, per-DUT monitors pop on each pulse.
module tb_sequence_detector_param;

    logic clock = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;

    logic       seq   = 1'b0;
    logic       vld   = 1'b0;
    logic       ovl   = 1'b0;
    logic       pload = 1'b0;
    logic [3:0] pin   = 4'b0000;
    logic       cclr  = 1'b0;

    int unsigned cyc = 0;
    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int unsigned cyc;
        int unsigned cnt;
        logic        sat;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    sequence_detector_param_if #(.PATTERN_W(4), .COUNT_W(8)) bus_a ();
    sequence_detector_param_if #(.PATTERN_W(4), .COUNT_W(2)) bus_b ();

    assign bus_a.sequence_in  = seq;
    assign bus_a.in_valid     = vld;
    assign bus_a.overlap_en   = ovl;
    assign bus_a.pattern_load = pload;
    assign bus_a.pattern_in   = pin;
    assign bus_a.count_clr    = cclr;
    assign bus_b.sequence_in  = seq;
    assign bus_b.in_valid     = vld;
    assign bus_b.overlap_en   = ovl;
    assign bus_b.pattern_load = pload;
    assign bus_b.pattern_in   = pin;
    assign bus_b.count_clr    = cclr;

    sequence_detector_param #(
        .PATTERN_W       (4),
        .DEFAULT_PATTERN (4'b1011),
        .COUNT_W         (8)
    ) dut_a (
        .clock   (clock),
        .reset_n (rst_a_n),
        .bus     (bus_a)
    );

    sequence_detector_param #(
        .PATTERN_W       (4),
        .DEFAULT_PATTERN (4'b1011),
        .COUNT_W         (2)
    ) dut_b (
        .clock   (clock),
        .reset_n (rst_b_n),
        .bus     (bus_b)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the 8-bit-count instance.
    always @(negedge clock) begin
        if (bus_a.detector_out === 1'b1) begin
            chk("a_pulse_expected", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) begin
                exp_t e;
                e = q_a.pop_front();
                chk("a_pulse_cycle", cyc, e.cyc);
                chk("a_pulse_count", 32'(bus_a.match_count), e.cnt);
                chk("a_pulse_sat", 32'(bus_a.count_sat), 32'(e.sat));
            end
        end
    end

    // Monitor for the 2-bit-count instance.
    always @(negedge clock) begin
        if (bus_b.detector_out === 1'b1) begin
            chk("b_pulse_expected", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) begin
                exp_t e;
                e = q_b.pop_front();
                chk("b_pulse_cycle", cyc, e.cyc);
                chk("b_pulse_count", 32'(bus_b.match_count), e.cnt);
                chk("b_pulse_sat", 32'(bus_b.count_sat), 32'(e.sat));
            end
        end
    end

    // One accepted bit; which: 0 no pulse, 1 pulse on dut_a, 2 pulse on dut_b.
    task automatic send(input logic b, input logic ov, input logic clr,
                        input int which, input int unsigned cnt, input logic sat);
        exp_t e;
        seq  = b;
        vld  = 1'b1;
        ovl  = ov;
        cclr = clr;
        e.cyc = cyc + 1;
        e.cnt = cnt;
        e.sat = sat;
        if (which == 1) q_a.push_back(e);
        if (which == 2) q_b.push_back(e);
        @(posedge clock);
        #1;
        vld  = 1'b0;
        cclr = 1'b0;
    endtask

    task automatic idle(input logic clr);
        vld  = 1'b0;
        cclr = clr;
        seq  = 1'b1;
        @(posedge clock);
        #1;
        cclr = 1'b0;
    endtask

    task automatic load(input logic [3:0] p);
        pload = 1'b1;
        pin   = p;
        vld   = 1'b1;
        seq   = 1'b1;
        @(posedge clock);
        #1;
        pload = 1'b0;
        vld   = 1'b0;
    endtask

    task automatic restart_a();
        rst_a_n = 1'b0;
        #2;
        rst_a_n = 1'b1;
    endtask

    task automatic check_a(input string tag, input int unsigned cnt, input logic sat);
        chk({tag, "_count"}, 32'(bus_a.match_count), cnt);
        chk({tag, "_sat"}, 32'(bus_a.count_sat), 32'(sat));
        chk({tag, "_det"}, 32'(bus_a.detector_out), 32'd0);
        chk({tag, "_drained"}, 32'(q_a.size()), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("reset_a_det", 32'(bus_a.detector_out), 32'd0);
        chk("reset_a_count", 32'(bus_a.match_count), 32'd0);
        chk("reset_a_sat", 32'(bus_a.count_sat), 32'd0);
        chk("reset_b_count", 32'(bus_b.match_count), 32'd0);
        rst_a_n = 1'b1;

        // 1: overlapping matches on 1,0,1,1,0,1,1
        send(1, 1, 0, 0, 0, 0);
        send(0, 1, 0, 0, 0, 0);
        send(1, 1, 0, 0, 0, 0);
        send(1, 1, 0, 1, 1, 0);
        send(0, 1, 0, 0, 0, 0);
        send(1, 1, 0, 0, 0, 0);
        send(1, 1, 0, 1, 2, 0);
        idle(0);
        idle(0);
        check_a("t1", 2, 0);

        // 2: non-overlapping, same stream
        restart_a();
        send(1, 0, 0, 0, 0, 0);
        send(0, 0, 0, 0, 0, 0);
        send(1, 0, 0, 0, 0, 0);
        send(1, 0, 0, 1, 1, 0);
        send(0, 0, 0, 0, 0, 0);
        send(1, 0, 0, 0, 0, 0);
        send(1, 0, 0, 0, 0, 0);
        idle(0);
        idle(0);
        check_a("t2", 1, 0);

        // 3: gap cycles between accepted bits
        restart_a();
        send(1, 1, 0, 0, 0, 0);
        idle(0);
        send(0, 1, 0, 0, 0, 0);
        idle(0);
        send(1, 1, 0, 0, 0, 0);
        idle(0);
        send(1, 1, 0, 1, 1, 0);
        idle(0);
        idle(0);
        check_a("t3", 1, 0);

        // 4: reload pattern mid-stream, count carried over
        send(1, 1, 0, 0, 0, 0);
        send(0, 1, 0, 0, 0, 0);
        send(1, 1, 0, 0, 0, 0);
        load(4'b1110);
        check_a("t4_load", 1, 0);
        send(1, 1, 0, 0, 0, 0);
        send(1, 1, 0, 0, 0, 0);
        send(1, 1, 0, 0, 0, 0);
        send(0, 1, 0, 1, 2, 0);
        idle(0);
        idle(0);
        check_a("t4", 2, 0);

        // 5: 2-bit counter saturation, then clear coincident with a match
        rst_a_n = 1'b0;
        rst_b_n = 1'b1;
        for (int r = 0; r < 5; r++) begin
            int unsigned c;
            c = (r < 3) ? r + 1 : 3;
            send(1, 0, 0, 0, 0, 0);
            send(0, 0, 0, 0, 0, 0);
            send(1, 0, 0, 0, 0, 0);
            send(1, 0, 0, 2, c, (c == 3));
        end
        idle(0);
        chk("t5_b_count_sat", 32'(bus_b.match_count), 32'd3);
        chk("t5_b_sat", 32'(bus_b.count_sat), 32'd1);
        send(1, 0, 0, 0, 0, 0);
        send(0, 0, 0, 0, 0, 0);
        send(1, 0, 0, 0, 0, 0);
        send(1, 0, 1, 2, 1, 0);
        idle(0);
        chk("t5_b_clr_match", 32'(bus_b.match_count), 32'd1);
        chk("t5_b_clr_sat", 32'(bus_b.count_sat), 32'd0);
        idle(1);
        chk("t5_b_clr_alone", 32'(bus_b.match_count), 32'd0);
        chk("t5_b_drained", 32'(q_b.size()), 32'd0);
        rst_b_n = 1'b0;
        rst_a_n = 1'b1;

        // 6: async reset mid-pattern restores default pattern and clears state
        send(1, 1, 0, 0, 0, 0);
        send(0, 1, 0, 0, 0, 0);
        send(1, 1, 0, 0, 0, 0);
        send(1, 1, 0, 1, 1, 0);
        idle(0);
        load(4'b0110);
        check_a("t6_load", 1, 0);
        send(1, 1, 0, 0, 0, 0);
        send(0, 1, 0, 0, 0, 0);
        send(1, 1, 0, 0, 0, 0);
        #1;
        rst_a_n = 1'b0;
        #1;
        chk("t6_in_reset_count", 32'(bus_a.match_count), 32'd0);
        #2;
        rst_a_n = 1'b1;
        #1;
        send(1, 1, 0, 0, 0, 0);
        idle(0);
        check_a("t6_after_reset", 0, 0);
        send(0, 1, 0, 0, 0, 0);
        send(1, 1, 0, 0, 0, 0);
        send(1, 1, 0, 1, 1, 0);
        idle(0);
        idle(0);
        check_a("t6_default_pattern", 1, 0);

        chk("final_q_b_drained", 32'(q_b.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
